// File: rtl/des_pkg.sv
// Shared DES key-schedule constants and helpers. The tables are the standard
// 1-based DES bit numbers, so they can be checked directly against FIPS 46-3.
package des_pkg;

  // PC-1: 64-bit key -> 56-bit C/D. Parity bits 8,16,...,64 never appear.
  localparam int PC1_TABLE [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: 56-bit C/D -> 48-bit subkey.
  localparam int PC2_TABLE [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Forward left-shift amounts s[1..16]; index with round-1.
  // Decrypt walks this backwards as right rotations.
  localparam int SHIFT_SCHED [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  // Subkey beat presented to the round function.
  typedef struct packed {
    logic [47:0] key;
    logic [3:0]  idx;
  } subkey_t;

  // Bit 1 of the DES numbering is the MSB of each vector.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1_TABLE[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2_TABLE[i])];
    return r;
  endfunction

  // Right rotation of a 28-bit half; the schedule only ever uses 1 or 2.
  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_pc2_comb.sv
// Purely combinational PC-2 compression (56 -> 48). Uses the same table as the
// forward key path so both directions stay bit-identical.
module des_pc2_comb
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  assign subkey = pc2(cd);

endmodule

// File: rtl/des_key_sched_dec.sv
// Decrypt-side DES key schedule. PC-1 is applied once at start, then C/D are
// rotated right between rounds so K16..K1 come out in order without storing
// all sixteen subkeys. Subkeys leave over a valid/ready stream.
module des_key_sched_dec
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key64,
  output logic [47:0] subkey48,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done
);

  state_t      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [4:0]  rnd_q, rnd_d;      // 16..1 while emitting
  logic        done_q, done_d;
  logic [3:0]  sidx;
  logic [1:0]  sh;
  logic        xfer;
  logic [47:0] pc2_out;
  subkey_t     sk;

  // Rotation that takes round rnd's C/D to round rnd-1's C/D is s[rnd].
  assign sidx = 4'(rnd_q - 5'd1);
  assign sh   = 2'(SHIFT_SCHED[sidx]);
  assign xfer = (state_q == EMIT) && subkey_ready;

  des_pc2_comb u_pc2 (
    .cd     (cd_q),
    .subkey (pc2_out)
  );

  assign sk.key = pc2_out;
  assign sk.idx = rnd_q[3:0];     // round 16 wraps to 0 by design

  assign subkey48     = sk.key;
  assign round_idx    = sk.idx;
  assign subkey_valid = (state_q == EMIT);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

  // State register; reset abandons any schedule and suppresses done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cd_q    <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

  // Next-state: load PC-1 on start, step C/D on each accepted subkey.
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cd_d    = pc1(key64);
          rnd_d   = 5'd16;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (xfer) begin
          if (rnd_q > 5'd1) begin
            cd_d  = {rotr28(cd_q[55:28], sh), rotr28(cd_q[27:0], sh)};
            rnd_d = rnd_q - 5'd1;
          end else begin
            // K1 accepted; C/D is left at C1/D1, start is honoured next cycle.
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_des_key_sched_dec.sv
// Self-checking bench for des_key_sched_dec. The reference computes the
// forward DES schedule (PC-1, left shifts, PC-2) and expects it reversed.
module tb_des_key_sched_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] key64;
  logic [47:0] subkey48;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;

  localparam int M_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int M_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int M_LS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_key_sched_dec dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .key64        (key64),
    .subkey48     (subkey48),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round_idx    (round_idx),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Forward schedule: K_r lives at bits [(r-1)*48 +: 48].
  function automatic logic [767:0] model_sched(input logic [63:0] k);
    logic [767:0] res;
    logic [27:0]  c, d;
    int p;
    res = '0;
    for (int i = 0; i < 28; i++) begin
      c[5'(27 - i)] = k[6'(64 - M_PC1[i])];
      d[5'(27 - i)] = k[6'(64 - M_PC1[i + 28])];
    end
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < M_LS[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      for (int j = 0; j < 48; j++) begin
        p = M_PC2[j];
        res[10'(r * 48 + 47 - j)] = (p <= 28) ? c[5'(28 - p)] : d[5'(56 - p)];
      end
    end
    return res;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; subkey_ready = 1'b0; key64 = '0;
    step(); step();
    n_assert++;
    if (subkey_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got v=%b b=%b d=%b want 0 0 0", subkey_valid, busy, done);
    end
    n_assert++;
    if (subkey48 !== 48'h0 || round_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_data got k=%h idx=%0d want 0 0", subkey48, round_idx);
    end
    rst = 1'b0;
    step();
    n_assert++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_known();
    logic [767:0] ks;
    logic [47:0]  want, gold;
    ks = model_sched(KEY_STD);
    key64 = KEY_STD; start = 1'b1; subkey_ready = 1'b1;
    step();
    start = 1'b0; key64 = {$urandom, $urandom};   // key only sampled at start
    for (int r = 16; r >= 1; r--) begin
      want = ks[(r - 1) * 48 +: 48];
      n_assert++;
      if (subkey_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
          round_idx !== 4'(r) || subkey48 !== want) begin
        n_fail++;
        $display("FAIL known_K%0d got v=%b b=%b d=%b idx=%0d k=%h want 1 1 0 %0d %h",
                 r, subkey_valid, busy, done, round_idx, subkey48, 4'(r), want);
      end
      case (r)
        16: gold = 48'hCB3D8B0E17F5;
        15: gold = 48'hBF918D3D3F0A;
        2:  gold = 48'h79AED9DBC9E5;
        default: gold = 48'h1B02EFFC7072;
      endcase
      if (r == 16 || r == 15 || r == 2 || r == 1) begin
        n_assert++;
        if (subkey48 !== gold) begin
          n_fail++;
          $display("FAIL known_gold_K%0d got %h want %h", r, subkey48, gold);
        end
      end
      step();
    end
    n_assert++;
    if (done !== 1'b1 || busy !== 1'b0 || subkey_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL known_done got d=%b b=%b v=%b want 1 0 0", done, busy, subkey_valid);
    end
    step();
    n_assert++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL known_done_pulse got d=%b want 0", done);
    end
  endtask

  task automatic test_backpressure();
    logic [767:0] ks;
    logic [47:0]  want;
    logic [63:0]  k;
    int r, cyc;
    for (int pass = 0; pass < 2; pass++) begin
      k = (pass == 0) ? KEY_STD : {$urandom, $urandom};
      ks = model_sched(k);
      key64 = k; start = 1'b1; subkey_ready = 1'b0;
      step();
      start = 1'b0;
      r = 16; cyc = 0;
      while (r > 0 && cyc < 200) begin
        want = ks[(r - 1) * 48 +: 48];
        n_assert++;
        if (subkey_valid !== 1'b1 || done !== 1'b0 || round_idx !== 4'(r) || subkey48 !== want) begin
          n_fail++;
          $display("FAIL bp%0d_K%0d got v=%b d=%b idx=%0d k=%h want 1 0 %0d %h",
                   pass, r, subkey_valid, done, round_idx, subkey48, 4'(r), want);
        end
        subkey_ready = (pass == 0) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
        if (subkey_ready) r--;
        step();
        cyc++;
      end
      n_assert++;
      if (cyc >= 200 || done !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL bp%0d_done got d=%b b=%b cyc=%0d want 1 0 <200", pass, done, busy, cyc);
      end
      subkey_ready = 1'b1;
      step();
    end
  endtask

  task automatic test_keys();
    logic [63:0]  klist [6];
    logic [767:0] ks;
    logic [47:0]  want, cst;
    klist[0] = 64'h0;
    klist[1] = 64'hFFFFFFFFFFFFFFFF;
    klist[2] = 64'h0101010101010101;
    for (int i = 3; i < 6; i++) klist[i] = {$urandom, $urandom};
    subkey_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ks = model_sched(klist[i]);
      cst = (i == 1) ? 48'hFFFFFFFFFFFF : 48'h0;
      key64 = klist[i]; start = 1'b1;
      step();
      start = 1'b0;
      for (int r = 16; r >= 1; r--) begin
        want = ks[(r - 1) * 48 +: 48];
        n_assert++;
        if (subkey_valid !== 1'b1 || round_idx !== 4'(r) || subkey48 !== want ||
            (i < 3 && subkey48 !== cst)) begin
          n_fail++;
          $display("FAIL keys%0d_K%0d got v=%b idx=%0d k=%h want 1 %0d %h",
                   i, r, subkey_valid, round_idx, subkey48, 4'(r), want);
        end
        step();
      end
      n_assert++;
      if (done !== 1'b1) begin
        n_fail++;
        $display("FAIL keys%0d_done got %b want 1", i, done);
      end
    end
    step();
  endtask

  task automatic test_start_ignored();
    logic [767:0] ks;
    logic [47:0]  want;
    ks = model_sched(KEY_STD);
    key64 = KEY_STD; start = 1'b1; subkey_ready = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      want = ks[(15 - cyc) * 48 +: 48];
      n_assert++;
      if (subkey_valid !== 1'b1 || round_idx !== 4'(16 - cyc) || subkey48 !== want) begin
        n_fail++;
        $display("FAIL ign_K%0d got v=%b idx=%0d k=%h want 1 %0d %h",
                 16 - cyc, subkey_valid, round_idx, subkey48, 4'(16 - cyc), want);
      end
      start = (cyc == 4);                            // cycle T+5
      key64 = (cyc == 4) ? 64'h0123456789ABCDEF : KEY_STD;
      step();
    end
    start = 1'b0;
    n_assert++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL ign_done got %b want 1", done);
    end
    step();
    n_assert++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_requeued got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [767:0] ks;
    ks = model_sched(KEY_STD);
    key64 = KEY_STD; start = 1'b1; subkey_ready = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 7; cyc++) step();        // now in T+8, K9 showing
    n_assert++;
    if (round_idx !== 4'd9 || subkey48 !== ks[8 * 48 +: 48]) begin
      n_fail++;
      $display("FAIL rstmid_K9 got idx=%0d k=%h want 9 %h", round_idx, subkey48, ks[8 * 48 +: 48]);
    end
    rst = 1'b1; start = 1'b1;                        // reset beats start
    step();
    rst = 1'b0; start = 1'b0;
    n_assert++;
    if (subkey_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || subkey48 !== 48'h0) begin
      n_fail++;
      $display("FAIL rstmid_clear got v=%b b=%b d=%b k=%h want 0 0 0 0",
               subkey_valid, busy, done, subkey48);
    end
    step();
    n_assert++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_nodone got d=%b b=%b want 0 0", done, busy);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_assert++;
    if (subkey_valid !== 1'b1 || round_idx !== 4'd0 || subkey48 !== ks[15 * 48 +: 48]) begin
      n_fail++;
      $display("FAIL rstmid_restart got v=%b idx=%0d k=%h want 1 0 %h",
               subkey_valid, round_idx, subkey48, ks[15 * 48 +: 48]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [767:0] ka, kb;
    logic [63:0]  keyb;
    logic [47:0]  want;
    keyb = {$urandom, $urandom};
    ka = model_sched(KEY_STD);
    kb = model_sched(keyb);
    key64 = KEY_STD; start = 1'b1; subkey_ready = 1'b1;
    step();
    start = 1'b0;
    for (int r = 16; r >= 1; r--) step();
    n_assert++;
    if (done !== 1'b1 || subkey48 !== ka[0 +: 48]) begin
      n_fail++;
      $display("FAIL b2b_done got d=%b k=%h want 1 %h", done, subkey48, ka[0 +: 48]);
    end
    key64 = keyb; start = 1'b1;                      // start in the done cycle
    step();
    start = 1'b0;
    for (int r = 16; r >= 1; r--) begin
      want = kb[(r - 1) * 48 +: 48];
      n_assert++;
      if (subkey_valid !== 1'b1 || done !== 1'b0 || round_idx !== 4'(r) || subkey48 !== want) begin
        n_fail++;
        $display("FAIL b2b_K%0d got v=%b d=%b idx=%0d k=%h want 1 0 %0d %h",
                 r, subkey_valid, done, round_idx, subkey48, 4'(r), want);
      end
      step();
    end
    n_assert++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done2 got d=%b b=%b want 1 0", done, busy);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_known();
    test_backpressure();
    test_keys();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/des_key_sched_dec.md
Name: des_key_sched_dec

Overview:
Decryption-side DES subkey generator. It produces the 16 round keys in reverse order (K16 first, K1 last) by applying PC-1 once and then rotating C/D right between rounds, instead of storing all 16 keys. Each subkey passes through PC-2. It feeds the decrypt datapath's round function over a valid/ready stream, with a start/done wrapper in the same style as the existing permutation stages.

Parameters:
None. All DES tables are fixed constants held in the package.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a schedule; sampled only in IDLE
key64  in  64  DES key; key64[63] = DES bit 1; parity bits (DES 8,16,...,64) are ignored
subkey48  out  48  current subkey; subkey48[47] = PC-2 output bit 1
subkey_valid  out  1  subkey48/round_idx are valid
subkey_ready  in  1  consumer accepts the subkey when valid && ready
round_idx  out  4  DES round number of subkey48; 16 is encoded as 4'd0, 15..1 as themselves
busy  out  1  high whenever the state is not IDLE
done  out  1  one-cycle pulse after K1 is accepted

Behaviour:
- Reset: rst=1 at a clock edge forces state=IDLE and cd=56'b0. It also clears round counter, subkey_valid, busy and done to 0. subkey48 then reads PC-2(0)=48'b0.
- Reset mid-operation abandons the schedule immediately. No done pulse is issued.
- Internal register cd[55:0]: C=cd[55:28], D=cd[27:0]. cd[55] = PC-1 output bit 1.
- States: IDLE and EMIT.
- IDLE:
  - When start=1 at an edge: cd <= PC1(key64), rnd <= 16, state <= EMIT.
  - key64 is sampled only at that edge; it may change afterwards.
- EMIT:
  - subkey_valid=1 and busy=1.
  - subkey48 = PC2(cd), combinational from the register. round_idx = rnd[3:0].
  - Latency: start sampled at edge T gives K16 valid in cycle T+1.
- Transfer occurs when subkey_valid && subkey_ready at an edge.
  - If rnd>1: cd <= {rotr28(C,s[rnd]), rotr28(D,s[rnd])}, rnd <= rnd-1.
  - If rnd==1: state <= IDLE and done <= 1 for exactly one cycle. subkey_valid and busy fall in that same cycle.
- Shift schedule s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Right-rotation amounts applied in order: s[16], s[15], ..., s[2].
  - Total is 27, so after K1 the state equals C1/D1 of the forward schedule.
- Backpressure: while subkey_valid=1 and subkey_ready=0, cd, rnd and subkey48 hold stable. There is no limit on stall length.
- Throughput: with subkey_ready held at 1, K16..K1 occupy 16 consecutive cycles.
- start while busy=1 is ignored and not queued. start in the cycle done=1 is accepted, since the state is IDLE.
- rst has priority over start and over any transfer.
- rotr28(x,n) = {x[n-1:0], x[27:n]} for n in {1,2}, applied to C and D independently.

Decomposition:
- Package des_pkg holds:
  - PC1_TABLE[56] and PC2_TABLE[48] (1-based DES bit numbers)
  - SHIFT_SCHED[16]
  - state enum {IDLE, EMIT}
  - helper functions pc1(), pc2(), rotr28()
- One natural sub-module: des_pc2_comb, a purely combinational 56->48 PC-2 used for subkey48. It shares PC2_TABLE with the forward path so the permutation stays consistent.

Test Plan:
- key64=64'h133457799BBCDFF1, subkey_ready=1, start pulse:
  - K16=48'hCB3D8B0E17F5 at T+1, round_idx=0
  - K15=48'hBF918D3D3F0A at T+2, round_idx=15
  - K2=48'h79AED9DBC9E5 at T+15
  - K1=48'h1B02EFFC7072 at T+16, round_idx=1
  - done=1 at T+17, busy=0 at T+17
- Same key, subkey_ready toggled 1,0,0,1,...:
  - each subkey held unchanged while ready=0
  - the same 16 values appear in the same order; done only after K1 is accepted
- key64=0 gives all 16 subkeys 48'h0. key64=64'hFFFFFFFFFFFFFFFF gives all subkeys 48'hFFFFFFFFFFFF. key64=64'h0101010101010101 (parity bits only) gives all subkeys 0.
- start pulsed again at T+5 with a different key: ignored, and the sequence continues with the original key's values.
- rst asserted at T+8 (K9 showing): at T+9 subkey_valid=0, busy=0, done=0, subkey48=0. A new start then yields K16 again.
- start asserted in the done cycle: the new schedule begins and its K16 is valid the following cycle.
